rom_stream_reader: RTL

// - Bus initiator for the asynchronous, active-low CS/OE ROM: sequences addresses, drives CS/OE,

---
 rtl/rom_stream_reader_pkg.sv | 19 +
 rtl/rom_stream_reader_if.sv | 24 ++
 rtl/rom_stream_reader_wait_counter.sv | 28 ++
 rtl/rom_stream_reader.sv | 93 +++++++++
 4 files changed

// File: rtl/rom_stream_reader_pkg.sv
// Shared types and helpers for the ROM stream reader: FSM state encoding
// and wait-counter sizing.
package rom_stream_reader_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_PRESENT = 2'd2,
    ST_FIN     = 2'd3
  } state_t;

  // A zero-wait build still needs a 1-bit counter so the port widths stay legal.
  function automatic int wait_cnt_width(input int wait_states);
    return (wait_states < 1) ? 1 : $clog2(wait_states + 1);
  endfunction

endpackage

// File: rtl/rom_stream_reader_if.sv
// ROM bus plus output valid/ready stream. The reader is the master; the ROM
// and the consumer together form the slave side.
interface rom_stream_reader_if #(
  parameter int AddressSize = 16,
  parameter int WordSize    = 8
);
  logic [AddressSize-1:0] rom_addr;
  logic                   rom_cs_n;
  logic                   rom_oe_n;
  logic [WordSize-1:0]    rom_data;
  logic [WordSize-1:0]    out_data;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output rom_addr, rom_cs_n, rom_oe_n, out_data, out_valid,
    input  rom_data, out_ready
  );

  modport slave (
    input  rom_addr, rom_cs_n, rom_oe_n, out_data, out_valid,
    output rom_data, out_ready
  );
endinterface

// File: rtl/rom_stream_reader_wait_counter.sv
// Loadable down-counter that times the ROM access; o_zero marks the sample cycle.
module rom_wait_counter #(
  parameter int Width = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_value,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [Width-1:0] r_count;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_dec && !o_zero) begin
      r_count <= r_count - Width'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/rom_stream_reader.sv
// Block reader for an asynchronous CS/OE ROM: walks addresses, times each
// access, and hands every captured word to a valid/ready consumer.
module rom_stream_reader
  import rom_stream_reader_pkg::*;
#(
  parameter int AddressSize = 16,
  parameter int WordSize    = 8,
  parameter int WaitStates  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_start,
  input  logic [AddressSize-1:0] i_base_addr,
  input  logic [AddressSize:0]   i_length,
  output logic                   o_busy,
  output logic                   o_done,
  rom_stream_reader_if.master    bus
);

  localparam int CntW = wait_cnt_width(WaitStates);
  localparam logic [CntW-1:0] CntLoad = CntW'(WaitStates);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [AddressSize-1:0] r_addr;
  logic [AddressSize:0]   r_remaining;
  logic [WordSize-1:0]    r_out_data;

  logic w_start_go;
  logic w_capture;
  logic w_accept;
  logic w_last;
  logic w_advance;
  logic w_cnt_zero;

  assign w_start_go = (r_state == ST_IDLE) && i_start && (i_length != '0);
  assign w_capture  = (r_state == ST_ACCESS) && w_cnt_zero;
  assign w_accept   = (r_state == ST_PRESENT) && bus.out_ready;
  assign w_last     = (r_remaining == (AddressSize+1)'(1));
  assign w_advance  = w_accept && !w_last;

  rom_wait_counter #(.Width(CntW)) u_wait_counter (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_start_go || w_advance),
    .i_load_value (CntLoad),
    .i_dec        (r_state == ST_ACCESS),
    .o_zero       (w_cnt_zero)
  );

  // NOTE: always_comb assigns a default first so no path leaves w_next_state latched.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (i_start) w_next_state = (i_length == '0) ? ST_FIN : ST_ACCESS;
      ST_ACCESS:  if (w_cnt_zero) w_next_state = ST_PRESENT;
      ST_PRESENT: if (bus.out_ready) w_next_state = w_last ? ST_FIN : ST_ACCESS;
      ST_FIN:     w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_out_data  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_start_go) begin
        r_addr      <= i_base_addr;
        r_remaining <= i_length;
      end
      if (w_capture) r_out_data <= bus.rom_data;
      // Address wraps naturally at the top of the ROM.
      if (w_advance) begin
        r_addr      <= r_addr + AddressSize'(1);
        r_remaining <= r_remaining - (AddressSize+1)'(1);
      end
    end
  end

  // CS and OE share one decode, so they can never disagree.
  assign bus.rom_addr  = r_addr;
  assign bus.rom_cs_n  = (r_state != ST_ACCESS);
  assign bus.rom_oe_n  = (r_state != ST_ACCESS);
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = (r_state == ST_PRESENT);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = (r_state == ST_FIN);

endmodule
